// File: rtl/matmul_pkg.sv
// Shared types and helpers for the streaming DIMxDIM matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned dim);
    return 2 * dw + $clog2(dim);
  endfunction

  // Zero- or sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] extend(input logic [63:0] v, input int unsigned w,
                                         input logic sgn);
    logic [63:0] msk;
    msk = (64'd1 << w) - 64'd1;
    if (sgn && ((v >> (w - 1)) & 64'd1) != 64'd0) return v | ~msk;
    return v & msk;
  endfunction

endpackage

// File: rtl/matmul_stream_mac_lane.sv
// One multiply-accumulate lane: acc <= (clr ? 0 : acc) + a*b while en is high.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic             clr,
  input  logic             en,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] a_x, b_x, prod;

  // Low ACC_W bits of the product of extended operands equal the extended exact product.
  always_comb begin
    a_x  = ACC_W'(extend(64'(a), DW, SIGNED != 0));
    b_x  = ACC_W'(extend(64'(b), DW, SIGNED != 0));
    prod = a_x * b_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? prod : acc + prod;
    end
  end

endmodule

// File: rtl/matmul_stream.sv
// Streaming C = A*B: load A then B row-major, compute one row per DIM cycles, drain C row-major.
module matmul_stream
  import matmul_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned DIM    = 4,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned ACC_W  = acc_width(DW, DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  state_t state_q, state_d;

  logic [DW-1:0]    a_buf [DIM][DIM];
  logic [DW-1:0]    b_buf [DIM][DIM];
  logic [ACC_W-1:0] c_buf [DIM][DIM];
  logic [ACC_W-1:0] acc   [DIM];

  logic [IW-1:0] ld_r, ld_c, ci, ck, wr_row, dr_r, dr_c;
  logic          ld_b, wr_q, in_acc, out_acc;

  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == LOAD);
    busy      = (state_q != LOAD);
    // The first DRAIN cycle writes back the final row, so output starts one cycle later.
    out_valid = (state_q == DRAIN) && !wr_q;
    out_last  = out_valid && (dr_r == LAST) && (dr_c == LAST);
    out_data  = out_valid ? c_buf[dr_r][dr_c] : '0;
    in_acc    = in_valid && in_ready;
    out_acc   = out_valid && out_ready;
    unique case (state_q)
      LOAD:    if (in_acc && ld_b && ld_r == LAST && ld_c == LAST) state_d = COMPUTE;
      COMPUTE: if (ci == LAST && ck == LAST) state_d = DRAIN;
      DRAIN:   if (out_acc && out_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
          c_buf[r][c] <= '0;
        end
      end
      ld_r   <= '0;
      ld_c   <= '0;
      ld_b   <= 1'b0;
      ci     <= '0;
      ck     <= '0;
      wr_q   <= 1'b0;
      wr_row <= '0;
      dr_r   <= '0;
      dr_c   <= '0;
    end else begin
      if (in_acc) begin
        if (ld_b) b_buf[ld_r][ld_c] <= in_data;
        else      a_buf[ld_r][ld_c] <= in_data;
        if (ld_c == LAST) begin
          ld_c <= '0;
          if (ld_r == LAST) begin
            ld_r <= '0;
            ld_b <= !ld_b;
          end else begin
            ld_r <= ld_r + 1'b1;
          end
        end else begin
          ld_c <= ld_c + 1'b1;
        end
      end

      wr_q   <= (state_q == COMPUTE) && (ck == LAST);
      wr_row <= ci;
      if (wr_q) begin
        for (int j = 0; j < DIM; j++) c_buf[wr_row][j] <= acc[j];
      end

      if (state_q == COMPUTE) begin
        if (ck == LAST) begin
          ck <= '0;
          ci <= (ci == LAST) ? '0 : ci + 1'b1;
        end else begin
          ck <= ck + 1'b1;
        end
      end

      if (out_acc) begin
        if (dr_c == LAST) begin
          dr_c <= '0;
          dr_r <= (dr_r == LAST) ? '0 : dr_r + 1'b1;
        end else begin
          dr_c <= dr_c + 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    mac_lane #(
      .DW    (DW),
      .ACC_W (ACC_W),
      .SIGNED(SIGNED)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .a  (a_buf[ci][ck]),
      .b  (b_buf[ck][j]),
      .clr(ck == '0),
      .en (state_q == COMPUTE),
      .acc(acc[j])
    );
  end

endmodule
